// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master round-robin Wishbone arbiter with stall watchdog
module wb_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_o,
    output logic [DATA_W-1:0] m0_dat_i,
    input  logic              m0_we,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    output logic              m0_ack,

    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_o,
    output logic [DATA_W-1:0] m1_dat_i,
    input  logic              m1_we,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    output logic              m1_ack,

    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic              s_we,
    output logic              s_cyc,
    output logic              s_stb,
    input  logic              s_ack,

    output logic [1:0]        grant,
    output logic              timeout_pulse,
    output logic [7:0]        timeout_count
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last_grant;
    logic [15:0] wd_cnt, wd_cnt_nxt;
    logic        term, term_nxt;
    logic [7:0]  tcount;
    logic        stalled;

    // Routing and arbitration; term marks the forced-termination cycle
    always_comb begin
        state_nxt = state;
        s_adr     = '0;
        s_dat_o   = '0;
        s_we      = 1'b0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_dat_i  = '0;
        m1_dat_i  = '0;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = last_grant ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_nxt = GNT0;
                end else if (m1_cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_o;
                s_we     = m0_we;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~term;
                m0_ack   = term | s_ack;
                m0_dat_i = term ? ERR_DATA : s_dat_i;
                grant    = 2'b01;
                if (!m0_cyc) begin
                    state_nxt = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_o;
                s_we     = m1_we;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~term;
                m1_ack   = term | s_ack;
                m1_dat_i = term ? ERR_DATA : s_dat_i;
                grant    = 2'b10;
                if (!m1_cyc) begin
                    state_nxt = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog only counts beats that keep the same owner across the edge
    always_comb begin
        stalled    = (state != IDLE) && (state_nxt == state) && s_stb && !s_ack;
        term_nxt   = stalled && (wd_cnt == WD_LIMIT);
        wd_cnt_nxt = (stalled && !term_nxt) ? wd_cnt + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= 16'd0;
            term       <= 1'b0;
            tcount     <= 8'd0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_cnt_nxt;
            term   <= term_nxt;
            if (state_nxt != IDLE) begin
                last_grant <= (state_nxt == GNT1);
            end
            if (term_nxt && tcount != 8'hFF) begin
                tcount <= tcount + 8'd1;
            end
        end
    end

    assign timeout_pulse = term;
    assign timeout_count = tcount;

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter placed in front of the address-decoding crossbar's CPU-side slave port.
- Lets the CPU data port (m0) and a second master (m1: instruction fetch or DMA) share memory and peripherals.
- Grants the bus per CYC cycle with round-robin fairness.
- Has a watchdog that terminates stalled transfers so an unresponsive slave cannot hang the core.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles STB may wait for ACK before forced termination (1..65535)
- ERR_DATA, 32'h00000000, read data returned on a timed-out transfer

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset
- m0_adr  in  ADDR_W  master 0 address
- m0_dat_o  in  DATA_W  master 0 write data
- m0_dat_i  out  DATA_W  master 0 read data
- m0_we  in  1  master 0 write enable
- m0_cyc  in  1  master 0 cycle request
- m0_stb  in  1  master 0 strobe
- m0_ack  out  1  master 0 acknowledge
- m1_adr, m1_dat_o, m1_dat_i, m1_we, m1_cyc, m1_stb, m1_ack: same as m0 for master 1
- s_adr  out  ADDR_W  to crossbar ADR
- s_dat_o  out  DATA_W  to crossbar DAT_O
- s_dat_i  in  DATA_W  from crossbar DAT_I
- s_we  out  1  to crossbar WE
- s_cyc  out  1  to crossbar CYC
- s_stb  out  1  to crossbar STB
- s_ack  in  1  from crossbar ACK
- grant  out  2  one-hot current owner (01=m0, 10=m1, 00=none)
- timeout_pulse  out  1  one-cycle pulse on forced termination
- timeout_count  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - state=IDLE, last_grant=m1 (so m0 wins the first tie), wd_cnt=0, timeout_count=0, timeout_pulse=0.
  - All outputs take their IDLE values.
  - Reset mid-transaction drops the grant immediately on the next edge; no ACK is issued to the aborted master.
- Registered state machine, states IDLE, GNT0, GNT1. Slave and master signals are routed combinationally from the current state.
- IDLE:
  - Outputs: s_cyc=s_stb=s_we=0, s_adr=0, s_dat_o=0, both m*_ack=0, both m*_dat_i=0, grant=00.
  - Only m0_cyc -> GNT0. Only m1_cyc -> GNT1.
  - Both -> grant the master not equal to last_grant. Neither -> stay.
  - Arbitration latency: 1 cycle from CYC to the grant appearing on the s_* port.
- GNTn:
  - s_adr/s_dat_o/s_we/s_cyc/s_stb = mn_*; mn_ack=s_ack; mn_dat_i=s_dat_i.
  - The other master sees ack=0 and dat_i=0. grant is one-hot n. On entry, last_grant<=n.
  - The grant is held for the full CYC, including multiple STB/ACK beats; no preemption.
  - When mn_cyc=0: if the other master's CYC=1, go directly to GNT(other) with no IDLE bubble; else go to IDLE.
- Watchdog:
  - In GNTn with mn_stb=1 and s_ack=0, wd_cnt increments; it clears on s_ack=1, when stb=0, or on a state change.
  - When wd_cnt==TIMEOUT-1 and s_ack is still 0, the next cycle is a termination cycle:
    - mn_ack=1, mn_dat_i=ERR_DATA, s_stb forced 0, timeout_pulse=1.
    - timeout_count increments, saturating at 255; wd_cnt clears.
  - A late s_ack arriving in the termination cycle is ignored (exactly one ACK per beat to the master).
- Simultaneous release and request of the same master (mn_cyc drops while the other idles and mn re-raises next cycle): mn is re-granted through IDLE.
- Widths: wd_cnt is 16 bits; comparisons are unsigned.

Test Plan:
- Only m0 read, adr 0x00000010, slave ACK after 2 cycles with 0xCAFEF00D -> grant=01 one cycle after CYC; m0_dat_i=0xCAFEF00D with m0_ack; m1_ack stays 0.
- m0 and m1 raise CYC in the same cycle, each doing one write -> m0 served first (grant=01), then GNT1 directly on m0 release with no IDLE cycle; a repeated tie is next won by m0 again only after m1 is served.
- m1 holds CYC for 3 beats (adr 0x00100000, 0x00100020, 0x00100030) while m0 requests -> m0 gets no ACK until m1 drops CYC; grant never toggles mid-cycle.
- TIMEOUT=4, slave never ACKs on m0 read -> m0_ack=1 with data 0x00000000 exactly 4 cycles after STB; s_stb=0 that cycle; timeout_pulse high 1 cycle; timeout_count=1.
- rst=0 while in GNT1 with STB pending -> next cycle grant=00, s_cyc=0, m1_ack never asserted; after release, a tie goes to m0.
- 300 forced timeouts -> timeout_count saturates at 255.
